// File: rtl/seq_trojan_delay_paths.sv
// -----------------------------------------------------------------------------
// seq_trojan_delay_paths
//
// CHANNELS independent gate-chain delay paths for FPGA delay/spy experiments.
// Each path is a keep-attributed chain of NAND(x,VCC) inverters with an XOR
// payload spliced in at mid-chain. The payload is driven by a trigger that
// either mirrors a pattern match combinationally or fires after TRIG_COUNT
// consecutive matching clock edges. A registered monitor compares every
// path's input against its output and latches sticky per-channel error flags.
//
// Ports
//   clk         single clock
//   rst         synchronous reset, active-high
//   VCC / GND   constant ties used as second gate inputs inside the chains
//   path_in     delay path inputs (CHANNELS)
//   path_out    delay path outputs, combinational through the chains
//   ht_in       trigger inputs (TRIG_W); a match is ht_in == PATTERN
//   mode        00 off, 01 combinational, 10 sequential-level,
//               11 sequential-sticky
//   ch_mask     per-channel payload enable
//   clear       synchronous clear of trigger and monitor state
//   armed       counting has started and the trigger has not fired yet
//   fired       registered trigger state
//   fire_count  saturating count of fired rising edges
//   err_flag    sticky per-channel input/output mismatch flags
//
// Trigger modes (mode_q)
//   MODE_OFF    | counter and fired held at 0, payload off
//   MODE_COMB   | payload follows match directly; fired is a 1-cycle mirror
//   MODE_LEVEL  | fires after TRIG_COUNT matches, drops on first non-match
//   MODE_STICKY | fires after TRIG_COUNT matches, holds until clear/rst/mode
// -----------------------------------------------------------------------------
module seq_trojan_delay_paths #(
    parameter int                CHANNELS   = 4,
    parameter int                STAGES     = 32,
    parameter int                TRIG_W     = 2,
    parameter logic [TRIG_W-1:0] PATTERN    = {TRIG_W{1'b1}},
    parameter int                TRIG_COUNT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                VCC,
    input  logic                GND,
    input  logic [CHANNELS-1:0] path_in,
    output logic [CHANNELS-1:0] path_out,
    input  logic [TRIG_W-1:0]   ht_in,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] ch_mask,
    input  logic                clear,
    output logic                armed,
    output logic                fired,
    output logic [7:0]          fire_count,
    output logic [CHANNELS-1:0] err_flag
);

    localparam int         HALF     = STAGES / 2;
    localparam logic [7:0] CNT_LAST = 8'(TRIG_COUNT - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_COMB   = 2'b01,
        MODE_LEVEL  = 2'b10,
        MODE_STICKY = 2'b11
    } mode_e;

    mode_e                mode_in;
    mode_e                mode_q;
    logic                 match;
    logic                 active;
    logic [CHANNELS-1:0]  payload;

    logic [7:0]           cnt_q,        cnt_d;
    logic                 fired_q,      fired_d;
    logic [7:0]           fire_count_q, fire_count_d;
    logic [CHANNELS-1:0]  err_q,        err_d;
    logic [CHANNELS-1:0]  in_q;
    logic [CHANNELS-1:0]  out_q;

    assign mode_in = mode_e'(mode);

    // -------------------------------------------------------------------------
    // Payload select. Mode 01 looks at the live mode input and live match so
    // the corruption appears in the same cycle, independent of the clock.
    // -------------------------------------------------------------------------
    always_comb begin
        match = (ht_in == PATTERN);
        case (mode_in)
            MODE_COMB:               active = match;
            MODE_LEVEL, MODE_STICKY: active = fired_q;
            default:                 active = 1'b0;
        endcase
        payload = {CHANNELS{active}} & ch_mask;
    end

    // -------------------------------------------------------------------------
    // Delay chains. Each stage lives in its own generate scope so every net is
    // a distinct keep-attributed signal and nothing is shared across channels.
    // An even stage count keeps the path non-inverting overall; the XOR sits
    // between the two halves.
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        (* keep = "true" *) logic head_n;
        (* keep = "true" *) logic xor_n;
        (* keep = "true" *) logic tail_n;

        assign head_n = path_in[c];

        for (genvar s = 0; s < HALF; s++) begin : g_pre
            (* keep = "true" *) logic n;
            if (s == 0) begin : g_first
                assign n = ~(head_n & VCC);
            end else begin : g_next
                assign n = ~(g_pre[s-1].n & VCC);
            end
        end

        assign xor_n = g_pre[HALF-1].n ^ payload[c];

        for (genvar s = 0; s < HALF; s++) begin : g_post
            (* keep = "true" *) logic n;
            if (s == 0) begin : g_first
                assign n = ~(xor_n & VCC);
            end else begin : g_next
                assign n = ~(g_post[s-1].n & VCC);
            end
        end

        assign tail_n      = g_post[HALF-1].n | GND;
        assign path_out[c] = tail_n;
    end

    // -------------------------------------------------------------------------
    // Trigger next state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        fired_d = fired_q;

        if (mode_in != mode_q) begin
            // any mode change restarts counting from scratch
            cnt_d   = 8'd0;
            fired_d = 1'b0;
        end else begin
            case (mode_q)
                MODE_OFF: begin
                    cnt_d   = 8'd0;
                    fired_d = 1'b0;
                end
                MODE_COMB: begin
                    cnt_d   = 8'd0;
                    fired_d = match;
                end
                MODE_LEVEL: begin
                    if (!match) begin
                        cnt_d   = 8'd0;
                        fired_d = 1'b0;
                    end else if (!fired_q) begin
                        if (cnt_q == CNT_LAST) fired_d = 1'b1;
                        else                   cnt_d   = cnt_q + 8'd1;
                    end
                end
                MODE_STICKY: begin
                    // once fired, ht_in no longer matters
                    if (!fired_q) begin
                        if (!match)                 cnt_d   = 8'd0;
                        else if (cnt_q == CNT_LAST) fired_d = 1'b1;
                        else                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                default: begin
                    cnt_d   = 8'd0;
                    fired_d = 1'b0;
                end
            endcase
        end

        if (clear) begin
            cnt_d   = 8'd0;
            fired_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Fire counter and monitor next state; clear overrides a coincident
    // rising edge or mismatch.
    // -------------------------------------------------------------------------
    always_comb begin
        fire_count_d = fire_count_q;
        if (fired_d && !fired_q && (fire_count_q != 8'hFF)) begin
            fire_count_d = fire_count_q + 8'd1;
        end
        err_d = err_q | (in_q ^ out_q);
        if (clear) begin
            fire_count_d = 8'd0;
            err_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= MODE_OFF;
            cnt_q        <= 8'd0;
            fired_q      <= 1'b0;
            fire_count_q <= 8'd0;
            err_q        <= '0;
            in_q         <= '0;
            out_q        <= '0;
        end else begin
            mode_q       <= mode_in;
            cnt_q        <= cnt_d;
            fired_q      <= fired_d;
            fire_count_q <= fire_count_d;
            err_q        <= err_d;
            // sampling continues through clear
            in_q         <= path_in;
            out_q        <= path_out;
        end
    end

    assign armed      = (cnt_q != 8'd0) && !fired_q;
    assign fired      = fired_q;
    assign fire_count = fire_count_q;
    assign err_flag   = err_q;

endmodule

// File: tb/tb_seq_trojan_delay_paths.sv
// -----------------------------------------------------------------------------
// Bench for seq_trojan_delay_paths. The reference model tracks the length of
// the current run of matching edges and derives fired/armed from it, rather
// than following a cycle-level counter.
// -----------------------------------------------------------------------------
module tb_seq_trojan_delay_paths;

    localparam int CH = 4;
    localparam int TC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          VCC = 1'b1;
    logic          GND = 1'b0;
    logic [CH-1:0] path_in;
    logic [CH-1:0] path_out;
    logic [1:0]    ht_in;
    logic [1:0]    mode;
    logic [CH-1:0] ch_mask;
    logic          clear;
    logic          armed;
    logic          fired;
    logic [7:0]    fire_count;
    logic [CH-1:0] err_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [1:0]    m_mode_prev;
    int            m_run;
    bit            m_fired;
    int            m_fc;
    logic [CH-1:0] m_err;
    logic [CH-1:0] m_inq;
    logic [CH-1:0] m_outq;

    seq_trojan_delay_paths #(
        .CHANNELS  (CH),
        .STAGES    (32),
        .TRIG_W    (2),
        .PATTERN   (2'b11),
        .TRIG_COUNT(TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .VCC       (VCC),
        .GND       (GND),
        .path_in   (path_in),
        .path_out  (path_out),
        .ht_in     (ht_in),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .clear     (clear),
        .armed     (armed),
        .fired     (fired),
        .fire_count(fire_count),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] exp_out();
        bit act;
        if (mode == 2'b01)  act = (ht_in == 2'b11);
        else if (mode[1])   act = m_fired;
        else                act = 1'b0;
        return path_in ^ (act ? ch_mask : '0);
    endfunction

    function automatic bit exp_armed();
        return m_mode_prev[1] && !m_fired && (m_run > 0);
    endfunction

    function automatic logic [13:0] exp_state();
        return {exp_armed(), m_fired, 8'(m_fc), m_err};
    endfunction

    // one clock edge of the reference model, using the inputs held at the edge
    task automatic model_step();
        bit            match;
        bit            prev_f;
        logic [CH-1:0] o;
        match  = (ht_in == 2'b11);
        prev_f = m_fired;
        o      = exp_out();
        if (rst) begin
            m_mode_prev = 2'b00;
            m_run = 0; m_fired = 0; m_fc = 0;
            m_err = '0; m_inq = '0; m_outq = '0;
            return;
        end
        m_err  = clear ? '0 : (m_err | (m_inq ^ m_outq));
        m_inq  = path_in;
        m_outq = o;
        if (clear || (mode != m_mode_prev)) begin
            m_run = 0; m_fired = 0;
        end else begin
            case (mode)
                2'b00: begin m_run = 0; m_fired = 0; end
                2'b01: begin m_run = 0; m_fired = match; end
                2'b10: begin
                    if (match) begin
                        if (m_run < 1000) m_run++;
                        m_fired = (m_run >= TC);
                    end else begin
                        m_run = 0; m_fired = 0;
                    end
                end
                default: begin
                    if (!m_fired) begin
                        if (match) begin
                            m_run++;
                            m_fired = (m_run >= TC);
                        end else begin
                            m_run = 0;
                        end
                    end
                end
            endcase
        end
        if (clear)                                 m_fc = 0;
        else if (m_fired && !prev_f && m_fc < 255) m_fc++;
        m_mode_prev = mode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0;
        mode = 2'($urandom); ht_in = 2'($urandom);
        ch_mask = 4'($urandom); path_in = 4'($urandom);
        tick(); tick();
        rst = 1'b0; mode = 2'b00;
        n_checks++;
        if ({armed, fired, fire_count, err_flag} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b, want all zero",
                     {armed, fired, fire_count, err_flag});
        end
    endtask

    task automatic test_mode_off();
        mode = 2'b00; ch_mask = 4'hF; ht_in = 2'b11;
        for (int i = 0; i < 12; i++) begin
            path_in = 4'($urandom);
            #1;
            n_checks++;
            if (path_out !== path_in) begin
                n_fail++;
                $display("FAIL off_path[%0d]: got %b, want %b", i, path_out, path_in);
            end
            tick();
            n_checks++;
            if ({fired, err_flag} !== 5'b0) begin
                n_fail++;
                $display("FAIL off_state[%0d]: fired/err got %b, want 0", i, {fired, err_flag});
            end
        end
    endtask

    task automatic test_level();
        logic [CH-1:0] pin;
        mode = 2'b10; ch_mask = 4'b0101; ht_in = 2'b00; clear = 1'b1;
        tick();
        clear = 1'b0;
        // short run of 7 matches must not fire
        for (int i = 0; i < TC - 1; i++) begin
            ht_in = 2'b11; tick();
            n_checks++;
            if ({armed, fired} !== 2'b10) begin
                n_fail++;
                $display("FAIL level_short[%0d]: armed/fired got %b, want 10", i, {armed, fired});
            end
        end
        ht_in = 2'b01; tick();
        n_checks++;
        if ({armed, fired} !== 2'b00) begin
            n_fail++;
            $display("FAIL level_abort: armed/fired got %b, want 00", {armed, fired});
        end
        // full run fires exactly at the 8th edge
        for (int i = 0; i < TC; i++) begin
            ht_in = 2'b11; tick();
            n_checks++;
            if (fired !== (i == TC - 1)) begin
                n_fail++;
                $display("FAIL level_fire[%0d]: fired got %b, want %b", i, fired, (i == TC - 1));
            end
        end
        pin = 4'($urandom); path_in = pin;
        #1;
        n_checks++;
        if (path_out !== (pin ^ 4'b0101)) begin
            n_fail++;
            $display("FAIL level_payload: got %b, want %b", path_out, pin ^ 4'b0101);
        end
        tick(); tick();
        n_checks++;
        if ({err_flag, fire_count} !== {4'b0101, 8'd1}) begin
            n_fail++;
            $display("FAIL level_monitor: err/fc got %b/%0d, want 0101/1", err_flag, fire_count);
        end
    endtask

    task automatic test_sticky();
        mode = 2'b11; ht_in = 2'b11;
        tick();
        for (int i = 0; i < TC; i++) tick();
        n_checks++;
        if (fired !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_fire: got %b, want 1", fired);
        end
        ht_in = 2'b00;
        for (int i = 0; i < 20; i++) begin
            path_in = 4'($urandom); tick();
            n_checks++;
            if ({armed, fired, fire_count, err_flag} !== exp_state()) begin
                n_fail++;
                $display("FAIL sticky_hold[%0d]: got %b, want %b", i,
                         {armed, fired, fire_count, err_flag}, exp_state());
            end
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_checks++;
        if ({fired, fire_count, err_flag} !== 13'd0) begin
            n_fail++;
            $display("FAIL sticky_clear: got %b, want 0", {fired, fire_count, err_flag});
        end
    endtask

    task automatic test_comb();
        logic [CH-1:0] pin;
        mode = 2'b01; ch_mask = 4'hF; ht_in = 2'b00;
        tick();
        ht_in = 2'b11; pin = 4'($urandom); path_in = pin;
        #1;
        n_checks++;
        if (path_out !== ~pin) begin
            n_fail++;
            $display("FAIL comb_payload: got %b, want %b", path_out, ~pin);
        end
        tick();
        ht_in = 2'b00;
        #1;
        n_checks++;
        if ({fired, path_out} !== {1'b1, pin}) begin
            n_fail++;
            $display("FAIL comb_mirror: fired/out got %b, want %b", {fired, path_out}, {1'b1, pin});
        end
        tick();
        n_checks++;
        if ({fired, err_flag} !== 5'b0_1111) begin
            n_fail++;
            $display("FAIL comb_err: fired/err got %b, want 01111", {fired, err_flag});
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'b11; ht_in = 2'b11; ch_mask = 4'($urandom); clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < TC; i++) tick();
        mode = 2'b10;
        tick();
        n_checks++;
        if ({fired, fire_count} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL switch_clear: fired/fc got %b/%0d, want 0/1", fired, fire_count);
        end
        for (int i = 0; i < TC; i++) begin
            tick();
            n_checks++;
            if (fired !== (i == TC - 1)) begin
                n_fail++;
                $display("FAIL switch_refire[%0d]: got %b, want %b", i, fired, (i == TC - 1));
            end
        end
        n_checks++;
        if (fire_count !== 8'd2) begin
            n_fail++;
            $display("FAIL switch_count: got %0d, want 2", fire_count);
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b10; ht_in = 2'b00;
        tick();
        ht_in = 2'b11;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_armed: got %b, want 1", armed);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if ({armed, fired, fire_count, err_flag} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrst_state: got %b, want 0", {armed, fired, fire_count, err_flag});
        end
    endtask

    task automatic test_saturate();
        mode = 2'b01; ch_mask = 4'hF; ht_in = 2'b00;
        tick();
        for (int i = 0; i < 520; i++) begin
            ht_in = (i % 2 == 0) ? 2'b11 : 2'b00;
            tick();
            n_checks++;
            if (fire_count !== 8'(m_fc)) begin
                n_fail++;
                $display("FAIL sat_track[%0d]: got %0d, want %0d", i, fire_count, m_fc);
            end
        end
        n_checks++;
        if (fire_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: got %0d, want 255", fire_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            ht_in   = ($urandom_range(0, 7) != 0) ? 2'b11 : 2'($urandom);
            ch_mask = 4'($urandom);
            path_in = 4'($urandom);
            clear   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            #1;
            n_checks++;
            if (path_out !== exp_out()) begin
                n_fail++;
                $display("FAIL rand_path[%0d]: got %b, want %b", i, path_out, exp_out());
            end
            tick();
            n_checks++;
            if ({armed, fired, fire_count, err_flag} !== exp_state()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got %b, want %b", i,
                         {armed, fired, fire_count, err_flag}, exp_state());
            end
        end
        rst = 1'b0; clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; mode = 2'b00; ht_in = 2'b00;
        ch_mask = 4'h0; path_in = 4'h0;
        m_mode_prev = 2'b00; m_run = 0; m_fired = 0; m_fc = 0;
        m_err = '0; m_inq = '0; m_outq = '0;
        @(negedge clk);
        test_reset();
        test_mode_off();
        test_level();
        test_sticky();
        test_comb();
        test_mode_switch();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
